// File: rtl/axi_lite_master_if.sv
// Command/response handshake plus AXI4-Lite master channels for axi_lite_master.
interface axi_lite_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [1:0]            rsp_resp;

   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_WIDTH-1:0] WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back, with a sticky watchdog on slow slaves.
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   axi_lite_master_if.master   bus,
   output logic                timeout_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

   state_t        state;
   logic [CW-1:0] wd_cnt;
   logic          aw_done;
   logic          w_done;

   assign bus.cmd_ready = (state == IDLE);

   // A channel counts as done if its handshake happened earlier or happens now.
   always_comb begin
      aw_done = !bus.AWVALID || bus.AWREADY;
      w_done  = !bus.WVALID  || bus.WREADY;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= IDLE;
         wd_cnt        <= '0;
         timeout_err   <= 1'b0;
         bus.ARVALID   <= 1'b0;
         bus.AWVALID   <= 1'b0;
         bus.WVALID    <= 1'b0;
         bus.RREADY    <= 1'b0;
         bus.BREADY    <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.ARADDR    <= '0;
         bus.AWADDR    <= '0;
         bus.WDATA     <= '0;
         bus.WSTRB     <= '0;
         bus.rsp_rdata <= '0;
         bus.rsp_resp  <= '0;
         bus.rsp_write <= 1'b0;
      end else begin
         // Watchdog covers only the AXI-facing states; RSP waits on our own client.
         if (state == IDLE) begin
            wd_cnt <= '0;
         end else if (state != RSP && wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt + 1'b1 == WD_MAX) timeout_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.rsp_write <= bus.cmd_write;
                  if (bus.cmd_write) begin
                     bus.AWADDR  <= bus.cmd_addr;
                     bus.WDATA   <= bus.cmd_wdata;
                     bus.WSTRB   <= bus.cmd_wstrb;
                     bus.AWVALID <= 1'b1;
                     bus.WVALID  <= 1'b1;
                     state       <= WR_REQ;
                  end else begin
                     bus.ARADDR  <= bus.cmd_addr;
                     bus.ARVALID <= 1'b1;
                     state       <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (bus.ARREADY) begin
                  bus.ARVALID <= 1'b0;
                  bus.RREADY  <= 1'b1;
                  state       <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (bus.RVALID) begin
                  bus.rsp_rdata <= bus.RDATA;
                  bus.rsp_resp  <= bus.RRESP;
                  bus.RREADY    <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RSP;
               end
            end
            WR_REQ: begin
               if (bus.AWVALID && bus.AWREADY) bus.AWVALID <= 1'b0;
               if (bus.WVALID && bus.WREADY)   bus.WVALID  <= 1'b0;
               if (aw_done && w_done) begin
                  bus.BREADY <= 1'b1;
                  state      <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bus.BVALID) begin
                  bus.rsp_resp  <= bus.BRESP;
                  bus.rsp_rdata <= '0;
                  bus.BREADY    <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RSP;
               end
            end
            RSP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed and randomized checks of axi_lite_master against a memory-backed
// behavioural slave with programmable per-channel latencies.
module tb_axi_lite_master;
   logic ACLK;
   logic ARESETN;
   logic timeout_err;

   axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .bus         (bus),
      .timeout_err (timeout_err)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   int unsigned ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
   logic        junk_cmds = 1'b0;

   // slave-side bookkeeping
   int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [3:0]  wr_strb;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         bus.ARREADY = 0; bus.RVALID = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
         r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
         if (ar_hs) begin bus.ARREADY = 0; ar_hs = 0; end
         else if (bus.ARVALID) begin
            if (ar_cnt >= ar_delay) begin
               bus.ARREADY = 1; ar_hs = 1; ar_cnt = 0; rd_addr = bus.ARADDR; r_pend = 1; r_cnt = 0;
            end else ar_cnt++;
         end
         if (r_hs) begin bus.RVALID = 0; r_hs = 0; end
         else if (r_pend && bus.RREADY) begin
            if (r_cnt >= r_delay) begin
               bus.RVALID = 1; bus.RDATA = mem_rd(rd_addr); bus.RRESP = rresp_cfg;
               r_hs = 1; r_pend = 0; r_cnt = 0;
            end else r_cnt++;
         end
         if (aw_hs) begin bus.AWREADY = 0; aw_hs = 0; end
         else if (bus.AWVALID && !aw_got) begin
            if (aw_cnt >= aw_delay) begin
               bus.AWREADY = 1; aw_hs = 1; aw_cnt = 0; wr_addr = bus.AWADDR; aw_got = 1;
            end else aw_cnt++;
         end
         if (w_hs) begin bus.WREADY = 0; w_hs = 0; end
         else if (bus.WVALID && !w_got) begin
            if (w_cnt >= w_delay) begin
               bus.WREADY = 1; w_hs = 1; w_cnt = 0; wr_data = bus.WDATA; wr_strb = bus.WSTRB; w_got = 1;
            end else w_cnt++;
         end
         if (aw_got && w_got && !aw_hs && !w_hs && !b_pend) begin
            slave_mem[wr_addr] = merge(mem_rd(wr_addr), wr_data, wr_strb);
            aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
         end
         if (b_hs) begin bus.BVALID = 0; b_hs = 0; end
         else if (b_pend && bus.BREADY) begin
            if (b_cnt >= b_delay) begin
               bus.BVALID = 1; bus.BRESP = bresp_cfg; b_hs = 1; b_pend = 0; b_cnt = 0;
            end else b_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      int unsigned n = 0;
      while (!bus.cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
      bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s;
      if (w) ref_mem[a] = merge(ref_rd(a), d, s);
      @(posedge ACLK); #1;
      bus.cmd_valid = junk_cmds;
      bus.cmd_write = 1'($urandom); bus.cmd_addr = 32'h40 + 4 * $urandom_range(0, 7);
      bus.cmd_wdata = $urandom; bus.cmd_wstrb = 4'($urandom);
      @(negedge ACLK);
   endtask

   task automatic wait_rsp(input logic w, input logic [31:0] d, input logic [1:0] r,
                           input int unsigned hold);
      int unsigned n = 0;
      while (!bus.rsp_valid && n < 200) begin @(negedge ACLK); n++; end
      chk("rsp_arrive", 32'(bus.rsp_valid), 1);
      chk("rsp_write", 32'(bus.rsp_write), 32'(w));
      chk("rsp_rdata", bus.rsp_rdata, d);
      chk("rsp_resp", 32'(bus.rsp_resp), 32'(r));
      for (int unsigned i = 0; i < hold; i++) begin
         @(negedge ACLK);
         chk("hold_valid", 32'(bus.rsp_valid), 1);
         chk("hold_rdata", bus.rsp_rdata, d);
         chk("hold_resp", 32'(bus.rsp_resp), 32'(r));
         chk("hold_cmd_ready", 32'(bus.cmd_ready), 0);
      end
      bus.cmd_valid = 0;
      bus.rsp_ready = 1;
      @(posedge ACLK); #1;
      bus.rsp_ready = 0;
      chk("rsp_drop", 32'(bus.rsp_valid), 0);
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
      @(negedge ACLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [1:0]  rr;
      int unsigned hold;

      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
      bus.rsp_ready = 0; bus.RDATA = 0; bus.RRESP = 0; bus.BRESP = 0;
      ARESETN = 0;
      repeat (2) @(negedge ACLK);
      chk("rst_arvalid", 32'(bus.ARVALID), 0);
      chk("rst_awvalid", 32'(bus.AWVALID), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      ARESETN = 1;
      @(negedge ACLK);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);

      // read with one-cycle ARREADY latency
      slave_mem[32'h10] = 32'hDEAD_BEEF; ref_mem[32'h10] = 32'hDEAD_BEEF;
      ar_delay = 1; r_delay = 0;
      send_cmd(0, 32'h10, 32'h0, 4'h0);
      chk("rd_arvalid", 32'(bus.ARVALID), 1);
      chk("rd_araddr", bus.ARADDR, 32'h10);
      chk("rd_busy_cmd_ready", 32'(bus.cmd_ready), 0);
      @(negedge ACLK);
      chk("rd_arvalid_held", 32'(bus.ARVALID), 1);
      wait_rsp(0, 32'hDEAD_BEEF, 2'b00, 0);

      // write: WREADY two cycles ahead of AWREADY
      ar_delay = 0; w_delay = 0; aw_delay = 2; b_delay = 0;
      send_cmd(1, 32'h4, 32'h1234_5678, 4'hF);
      chk("wr_awvalid", 32'(bus.AWVALID), 1);
      chk("wr_wvalid", 32'(bus.WVALID), 1);
      chk("wr_wdata", bus.WDATA, 32'h1234_5678);
      chk("wr_wstrb", 32'(bus.WSTRB), 32'hF);
      @(negedge ACLK);
      chk("wr_wvalid_dropped", 32'(bus.WVALID), 0);
      chk("wr_awvalid_held", 32'(bus.AWVALID), 1);
      chk("wr_awaddr_held", bus.AWADDR, 32'h4);
      @(negedge ACLK);
      chk("wr_awvalid_held2", 32'(bus.AWVALID), 1);
      wait_rsp(1, 32'h0, 2'b00, 0);

      // read back through the slave
      aw_delay = 0;
      send_cmd(0, 32'h4, 32'h0, 4'h0);
      wait_rsp(0, 32'h1234_5678, 2'b00, 0);

      // SLVERR pass-through with 5 cycles of response backpressure
      rresp_cfg = 2'b10;
      send_cmd(0, 32'h4, 32'h0, 4'h0);
      wait_rsp(0, 32'h1234_5678, 2'b10, 5);
      rresp_cfg = 2'b00;

      // randomized traffic, junk on cmd_* while busy
      junk_cmds = 1;
      for (int unsigned t = 0; t < 40; t++) begin
         w = 1'($urandom);
         a = 32'h40 + 4 * $urandom_range(0, 7);
         d = $urandom;
         s = 4'($urandom);
         rr = 2'($urandom);
         hold = $urandom_range(0, 2);
         ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
         aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
         b_delay = $urandom_range(0, 2);
         if (w) bresp_cfg = rr; else rresp_cfg = rr;
         send_cmd(w, a, d, s);
         wait_rsp(w, w ? 32'h0 : ref_rd(a), rr, hold);
      end
      junk_cmds = 0;
      ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
      rresp_cfg = 2'b00; bresp_cfg = 2'b00;
      chk("no_timeout_normal", 32'(timeout_err), 0);

      // watchdog: ARREADY held off 20 cycles, limit 8
      ar_delay = 20;
      send_cmd(0, 32'h44, 32'h0, 4'h0);
      repeat (7) @(negedge ACLK);
      chk("wd_before_limit", 32'(timeout_err), 0);
      @(negedge ACLK);
      chk("wd_at_limit", 32'(timeout_err), 1);
      chk("wd_arvalid", 32'(bus.ARVALID), 1);
      repeat (4) @(negedge ACLK);
      chk("wd_arvalid_late", 32'(bus.ARVALID), 1);
      chk("wd_araddr_late", bus.ARADDR, 32'h44);
      wait_rsp(0, ref_rd(32'h44), 2'b00, 0);
      chk("wd_sticky", 32'(timeout_err), 1);
      ar_delay = 0;

      // reset while waiting for BVALID
      b_delay = 50;
      send_cmd(1, 32'h20, 32'hCAFE_F00D, 4'hF);
      repeat (3) @(negedge ACLK);
      chk("wr_resp_bready", 32'(bus.BREADY), 1);
      #2 ARESETN = 0;
      #1;
      chk("ar_bready", 32'(bus.BREADY), 0);
      chk("ar_awvalid", 32'(bus.AWVALID), 0);
      chk("ar_wvalid", 32'(bus.WVALID), 0);
      chk("ar_arvalid", 32'(bus.ARVALID), 0);
      chk("ar_rready", 32'(bus.RREADY), 0);
      chk("ar_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("ar_timeout", 32'(timeout_err), 0);
      chk("ar_awaddr", bus.AWADDR, 0);
      chk("ar_araddr", bus.ARADDR, 0);
      chk("ar_wdata", bus.WDATA, 0);
      chk("ar_wstrb", 32'(bus.WSTRB), 0);
      chk("ar_rsp_rdata", bus.rsp_rdata, 0);
      chk("ar_rsp_resp", 32'(bus.rsp_resp), 0);
      chk("ar_rsp_write", 32'(bus.rsp_write), 0);
      @(negedge ACLK);
      ARESETN = 1;
      b_delay = 0;
      @(posedge ACLK); #1;
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 0);
      end
      send_cmd(0, 32'h20, 32'h0, 4'h0);
      wait_rsp(0, 32'hCAFE_F00D, 2'b00, 0);
      send_cmd(1, 32'h24, 32'h0BAD_0001, 4'h3);
      wait_rsp(1, 32'h0, 2'b00, 1);
      send_cmd(0, 32'h24, 32'h0, 4'h0);
      wait_rsp(0, ref_rd(32'h24), 2'b00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 32, address width.
- DATA_WIDTH, default 32, data width; STRB_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, default 256, watchdog limit.

REQ-002 Ports SHALL be (name direction width meaning):
- ACLK in 1 clock.
- ARESETN in 1 asynchronous active-low reset.
- cmd_valid in 1 command request.
- cmd_ready out 1 command accept.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_WIDTH byte address.
- cmd_wdata in DATA_WIDTH write data.
- cmd_wstrb in STRB_WIDTH byte strobes.
- rsp_valid out 1, rsp_ready in 1: response handshake.
- rsp_write out 1 echo of cmd_write.
- rsp_rdata out DATA_WIDTH read data.
- rsp_resp out 2 AXI response.
- timeout_err out 1 sticky watchdog flag.
- AXI master side, AXI4-Lite directions: ARADDR ARVALID ARREADY; RDATA RRESP RVALID RREADY; AWADDR AWVALID AWREADY; WDATA WSTRB WVALID WREADY; BRESP BVALID BREADY.

Function
REQ-003 Outstanding transactions SHALL be limited to one; every output SHALL be driven from a register, except cmd_ready, which SHALL be combinational: (state==IDLE).

REQ-004 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.

REQ-005 IDLE, on cmd_valid&&cmd_ready:
- latch addr, wdata, wstrb and write;
- go to WR_REQ if cmd_write, else RD_ADDR.

REQ-006 RD_ADDR SHALL hold ARVALID=1 with ARADDR = latched addr from the cycle after acceptance until ARVALID&&ARREADY; ARVALID SHALL drop the following cycle; state SHALL go to RD_DATA.

REQ-007 RD_DATA SHALL hold RREADY=1; on RVALID&&RREADY it SHALL capture RDATA into rsp_rdata and RRESP into rsp_resp, drop RREADY, and go to RSP.

REQ-008 WR_REQ SHALL assert AWVALID and WVALID in the same cycle with the latched AWADDR/WDATA/WSTRB.
- Each VALID SHALL deassert independently the cycle after its own handshake.
- Either handshake may occur first.
- State SHALL go to WR_RESP once both handshakes are complete, including the case where both complete in the same cycle.

REQ-009 WR_RESP SHALL hold BREADY=1; on BVALID&&BREADY it SHALL capture BRESP into rsp_resp, set rsp_rdata=0, drop BREADY, and go to RSP.

REQ-010 RSP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then return to IDLE; a new command SHALL be accepted no earlier than the cycle after.

REQ-011 Once asserted, ARVALID, AWVALID and WVALID SHALL NOT deassert, and their payload SHALL NOT change, before the corresponding READY.

REQ-012 Non-OKAY responses (SLVERR, DECERR, EXOKAY) SHALL be passed through unchanged with no retry.

REQ-013 Watchdog:
- A counter SHALL count cycles spent in RD_ADDR, RD_DATA, WR_REQ and WR_RESP, and SHALL clear on entry to IDLE.
- When it reaches TIMEOUT_CYCLES, timeout_err SHALL set and stay set until reset.
- The counter SHALL saturate.
- The FSM SHALL keep waiting and SHALL NOT abandon the AXI handshake.

REQ-014 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-015 ARESETN low SHALL immediately and asynchronously force:
- state to IDLE;
- ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, timeout_err to 0;
- ARADDR, AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write to 0;
- the watchdog counter to 0.

REQ-016 Reset asserted mid-transaction SHALL discard that transaction with no response; cmd_ready SHALL be 1 on the first clock edge after ARESETN deasserts.

Verification
REQ-017 Read with slave ARREADY one cycle after ARVALID:
- stimulus: cmd read addr 0x0000_0010; slave returns RDATA 0xDEAD_BEEF, RRESP OKAY;
- required: rsp_valid=1, rsp_write=0, rsp_rdata=0xDEAD_BEEF, rsp_resp=00.

REQ-018 Write with WREADY two cycles before AWREADY:
- stimulus: cmd write addr 0x0000_0004, wdata 0x1234_5678, wstrb 0xF;
- required: WVALID drops first while AWVALID holds; BRESP OKAY yields rsp_write=1, rsp_resp=00, rsp_rdata=0.

REQ-019 Write followed by read to addr 0x0000_0004 against the codebase AXI-lite slave -> rsp_rdata=0x1234_5678.

REQ-020 Error and backpressure:
- stimulus: slave returns RRESP=2'b10 and rsp_ready is held low 5 cycles;
- required: rsp_valid and rsp_resp=10 stay stable for 5 cycles; cmd_ready=0 throughout.

REQ-021 Timeout, TIMEOUT_CYCLES=8:
- stimulus: ARREADY held low 20 cycles;
- required: timeout_err=1 after 8 cycles in RD_ADDR, ARVALID remains 1; after ARREADY and RVALID complete the read normally, timeout_err stays 1.

REQ-022 Reset in WR_RESP with BVALID low:
- required: all outputs 0 immediately; no rsp_valid after release; next command accepted normally.
